// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the digit-serial adder.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output start, sub, a, b, cin,
      input  ready, done, sum, cout, overflow
   );

   modport slave (
      input  start, sub, a, b, cin,
      output ready, done, sum, cout, overflow
   );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT_W bits per clock through a registered
// ripple carry. Result, carry-out and overflow update only when an operation
// completes and hold until the next completion.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | ready=1, waiting for start; outputs hold last result
// S_RUN  | one digit per clock, LSB first, NDIG clocks total
// S_DONE | done=1 for one cycle, then back to S_IDLE unconditionally
module serial_adder #(
   parameter int WIDTH   = 8,
   parameter int DIGIT_W = 2
) (
   input  logic          clk,
   input  logic          rst,
   serial_adder_if.slave bus
);
   localparam int NDIG  = WIDTH / DIGIT_W;
   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

   generate
      if (WIDTH < 1 || DIGIT_W < 1 || (WIDTH % DIGIT_W) != 0) begin : g_bad_param
         $fatal(1, "serial_adder: DIGIT_W must be >= 1 and divide WIDTH exactly");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic               a_msb_q, a_msb_d;
   logic               b_msb_q, b_msb_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic [DIGIT_W:0]         dsum;
   logic [WIDTH+DIGIT_W-1:0] acc_shift;
   logic [WIDTH-1:0]         acc_next;
   logic [WIDTH-1:0]         b_eff;

   // Next-state, datapath and result update for the three-state sequencer.
   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      carry_d = carry_q;
      count_d = count_q;
      acc_d   = acc_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      // Subtraction is a + ~b + 1, so the inverted operand is what gets stored.
      b_eff     = bus.sub ? ~bus.b : bus.b;
      dsum      = {1'b0, op_a_q[DIGIT_W-1:0]} + {1'b0, op_b_q[DIGIT_W-1:0]}
                  + {{DIGIT_W{1'b0}}, carry_q};
      // New digit enters at the MSB end; after NDIG digits bit order is restored.
      acc_shift = {dsum[DIGIT_W-1:0], acc_q};
      acc_next  = acc_shift[WIDTH+DIGIT_W-1:DIGIT_W];

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               op_a_d  = bus.a;
               op_b_d  = b_eff;
               carry_d = bus.sub ? 1'b1 : bus.cin;
               count_d = '0;
               a_msb_d = bus.a[WIDTH-1];
               b_msb_d = b_eff[WIDTH-1];
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            op_a_d  = op_a_q >> DIGIT_W;
            op_b_d  = op_b_q >> DIGIT_W;
            acc_d   = acc_next;
            carry_d = dsum[DIGIT_W];
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(NDIG - 1)) begin
               sum_d   = acc_next;
               cout_d  = dsum[DIGIT_W];
               ovf_d   = (a_msb_q == b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Register all state; synchronous reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         carry_q <= 1'b0;
         count_q <= '0;
         acc_q   <= '0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         carry_q <= carry_d;
         count_q <= count_d;
         acc_q   <= acc_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.ready    = (state_q == S_IDLE);
   assign bus.done     = (state_q == S_DONE);
   assign bus.sum      = sum_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle digit-serial adder/subtractor. Successor to the single-bit registered full adder.
- Adds or subtracts two WIDTH-bit operands, DIGIT_W bits per clock, through a ripple carry held in a register.
- Uses a start/ready/done handshake. Sits between operand registers and result consumers when a wide single-cycle adder would cost too much area.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be at least 1.
- DIGIT_W, 2, bits processed per clock. Must be at least 1 and divide WIDTH exactly. A violation is a fatal elaboration error.
- NDIG (derived, localparam) = WIDTH/DIGIT_W, the number of digit cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Accepted only when ready=1.
- sub  in  1  0 = add (a+b+cin); 1 = subtract (a-b, cin ignored).
- a  in  WIDTH  operand A. Sampled only on accepted start.
- b  in  WIDTH  operand B. Sampled only on accepted start.
- cin  in  1  carry-in for add mode.
- ready  out  1  high in IDLE only.
- done  out  1  single-cycle pulse: result valid.
- sum  out  WIDTH  result, low WIDTH bits.
- cout  out  1  carry out. In subtract mode 1 = no borrow.
- overflow  out  1  two's-complement signed overflow.

Behaviour:
- Reset: only one clock and a synchronous active-high reset (rst) sampled on the rising edge of clk. When rst=1 at an edge:
  - state becomes IDLE.
  - sum=0, cout=0, overflow=0, done=0, ready=1.
  - Internal shift registers, carry and digit counter are cleared.
  - rst has priority over every other input in every state.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - If start=1 at an edge: capture opA=a and opB = sub ? ~b : b. Set carry = sub ? 1 : cin. Set count=0 and go to RUN.
  - sum, cout and overflow keep their previous values.
- RUN:
  - ready=0.
  - Each edge computes {c, d} = opA[DIGIT_W-1:0] + opB[DIGIT_W-1:0] + carry.
  - opA and opB shift right by DIGIT_W.
  - d shifts into the accumulating result from the MSB end. After NDIG digits, the result sits in bit order.
  - carry <= c and count++.
  - On the edge processing digit NDIG-1:
    - sum <= final result. cout <= c.
    - overflow <= (A_msb == B'_msb) && (result_msb != A_msb), where B' is the possibly inverted operand B.
    - Go to DONE.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE unconditionally.
  - ready=0 in DONE, so start asserted in DONE is ignored.
- Latency: start accepted at edge E0 gives done=1 in the cycle following edge E0+NDIG.
  - Throughput is one operation per NDIG+2 cycles, because IDLE must be revisited.
- sum, cout and overflow:
  - Hold until the next operation completes. They are not cleared on a new start.
  - They are not updated mid-RUN. Intermediate digits live in an internal register only.
- start while ready=0: ignored with no side effects. Operand or sub changes during RUN have no effect.
- Reset during RUN or DONE: return to IDLE immediately. No done pulse; outputs are zeroed.
- NDIG=1 (DIGIT_W=WIDTH): RUN lasts one cycle, so done appears 1 cycle after the accepting edge.
- Carry wrap: the carry out of the final digit goes to cout only. It never feeds back into the next operation.

Test Plan:
- WIDTH=8, DIGIT_W=2, add, a=0x3C, b=0x5A, cin=0 -> sum=0x96, cout=0, overflow=1. done rises exactly 4 cycles after the start edge and lasts 1 cycle. ready returns 1 one cycle later.
- Add, a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, overflow=0.
- Subtract, a=0x05, b=0x07 (cin=1 applied, must be ignored) -> sum=0xFE, cout=0, overflow=0. Then subtract a=0x80, b=0x01 -> sum=0x7F, cout=1, overflow=1.
- Busy and reset handling:
  - Re-assert start and change a/b every cycle during RUN -> ignored; result unchanged at 0x96 for the first case.
  - Assert rst on RUN cycle 2 -> next cycle ready=1, sum=0, done never pulses.
- Back-to-back operation: hold start=1 continuously -> a new operation is accepted on each IDLE cycle, giving done pulses every 6 cycles. sum holds its old value until each new done.
- Parameter sweep: WIDTH=8 with DIGIT_W in {1, 8} and WIDTH=32 with DIGIT_W=4, using random operands -> results match a+b+cin or a-b; done latency is 8, 1 and 8 cycles respectively.
